// File: rtl/clmul_pkg.sv
// Shared types and widths for the carry-less product reduction stage.
package clmul_pkg;
   localparam int unsigned PROD_W = 64;
   localparam int unsigned REM_W  = 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} reduce_state_t;
endpackage

// File: rtl/gf2_div_step.sv
// One GF(2) LFSR division step: shift in the next product bit, fold in g on carry-out.
module gf2_div_step
   import clmul_pkg::*;
(
   input  logic [REM_W-1:0] rem,
   input  logic             next_bit,
   input  logic [REM_W-1:0] g,
   output logic [REM_W-1:0] rem_next
);

   assign rem_next = {rem[REM_W-2:0], next_bit} ^ (rem[REM_W-1] ? g : '0);

endmodule

// File: rtl/clmul_reduce.sv
// Iterative reduction of a 64-bit carry-less product modulo x^32 + g,
// retiring BITS_PER_CYCLE quotient bits per RUN cycle.
module clmul_reduce
   import clmul_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic [REM_W-1:0]  in_poly,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REM_W-1:0]  out_rem,
   output logic              busy
);

   localparam int unsigned NSTEPS = REM_W / BITS_PER_CYCLE;
   localparam int unsigned CNT_W  = $clog2(NSTEPS + 1);

   if (REM_W % BITS_PER_CYCLE != 0) begin : g_bad_bits_per_cycle
      $error("clmul_reduce: BITS_PER_CYCLE must divide 32");
   end

   reduce_state_t     state;
   logic [REM_W-1:0]  rem;
   logic [REM_W-1:0]  low;
   logic [REM_W-1:0]  g;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic [REM_W-1:0]  chain [BITS_PER_CYCLE+1];

   // Feed bits leave low MSB first, so step i consumes low[31-i].
   assign chain[0] = rem;
   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      gf2_div_step u_step (
         .rem      (chain[i]),
         .next_bit (low[REM_W-1-i]),
         .g        (g),
         .rem_next (chain[i+1])
      );
   end

   assign in_ready  = !stall && !reset && (state == IDLE || (state == DONE && out_ready));
   assign out_valid = !stall && (state == DONE);
   assign accept    = in_valid && in_ready;
   assign out_rem   = rem;
   assign busy      = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rem   <= '0;
         low   <= '0;
         g     <= '0;
         cnt   <= '0;
      end else if (!stall) begin
         if (accept) begin
            rem   <= in_prod[PROD_W-1:REM_W];
            low   <= in_prod[REM_W-1:0];
            g     <= in_poly;
            cnt   <= CNT_W'(NSTEPS);
            state <= RUN;
         end else begin
            case (state)
               RUN: begin
                  rem <= chain[BITS_PER_CYCLE];
                  low <= low << BITS_PER_CYCLE;
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= DONE;
               end
               DONE: if (out_ready) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clmul_reduce.sv
// Scoreboard bench for clmul_reduce at BITS_PER_CYCLE 8, 1 and 32.
module tb_clmul_reduce;
   import clmul_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  reset, stall, in_valid, out_ready;
   logic [2:0]  in_ready, out_valid, busy;
   logic [63:0] in_prod;
   logic [31:0] in_poly;
   logic [31:0] out_rem [3];

   int checks = 0;
   int errors = 0;
   logic [31:0] sb [$];

   clmul_reduce #(.BITS_PER_CYCLE(8)) u_dut8 (
      .clk(clk), .reset(reset[0]), .stall(stall[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .in_prod(in_prod), .in_poly(in_poly),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_rem(out_rem[0]), .busy(busy[0]));
   clmul_reduce #(.BITS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .reset(reset[1]), .stall(stall[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .in_prod(in_prod), .in_poly(in_poly),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_rem(out_rem[1]), .busy(busy[1]));
   clmul_reduce #(.BITS_PER_CYCLE(32)) u_dut32 (
      .clk(clk), .reset(reset[2]), .stall(stall[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .in_prod(in_prod), .in_poly(in_poly),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_rem(out_rem[2]), .busy(busy[2]));

   function automatic int nsteps(int k);
      case (k)
         0: return 4;
         1: return 32;
         default: return 1;
      endcase
   endfunction

   // Schoolbook long division: cancel each set bit from x^63 down to x^32.
   function automatic logic [31:0] ref_mod(logic [63:0] p, logic [31:0] gl);
      logic [63:0] r;
      logic [63:0] gfull;
      r = p;
      for (int i = 63; i >= 32; i--) begin
         if (r[i]) begin
            gfull = ({32'h0, gl} << (i - 32)) | (64'h1 << i);
            r = r ^ gfull;
         end
      end
      return r[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(int k, logic [63:0] prod, logic [31:0] poly,
                         logic [31:0] exp, bit push, string name);
      in_prod = prod;
      in_poly = poly;
      in_valid[k] = 1'b1;
      #1;
      checks++;
      if (in_ready[k] !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready dut%0d: got %b expected 1", name, k, in_ready[k]);
      end
      tick();
      in_valid[k] = 1'b0;
      in_poly = ~poly;
      if (push) sb.push_back(exp);
      checks++;
      if (busy[k] !== 1'b1) begin
         errors++;
         $display("FAIL %s busy dut%0d: got %b expected 1", name, k, busy[k]);
      end
   endtask

   // Counts cycles from the accept edge; s>0 stalls the edges T+s and T+s+1.
   task automatic wait_out(int k, int s, string name);
      int c;
      int lat_exp;
      c = 0;
      lat_exp = nsteps(k) + 1 + ((s != 0) ? 2 : 0);
      stall[k] = (s == 1);
      forever begin
         tick();
         c++;
         if (out_valid[k] === 1'b1) break;
         if (c > 300) break;
         stall[k] = (s != 0) && (c + 1 >= s) && (c + 1 < s + 2);
      end
      stall[k] = 1'b0;
      checks++;
      if (c + 1 != lat_exp) begin
         errors++;
         $display("FAIL %s latency dut%0d: got %0d expected %0d", name, k, c + 1, lat_exp);
      end
   endtask

   task automatic take(int k, int hold, bit b2b, logic [63:0] prod2, logic [31:0] poly2,
                       logic [31:0] exp2, string name);
      logic [31:0] exp;
      if (sb.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL %s scoreboard empty dut%0d: got 0 entries expected 1", name, k);
         return;
      end
      exp = sb.pop_front();
      for (int h = 0; h < hold; h++) begin
         checks++;
         if (out_valid[k] !== 1'b1 || out_rem[k] !== exp) begin
            errors++;
            $display("FAIL %s hold dut%0d: got v=%b rem=%h expected v=1 rem=%h",
                     name, k, out_valid[k], out_rem[k], exp);
         end
         if (h == 1) begin
            stall[k] = 1'b1;
            #1;
            checks++;
            if (out_valid[k] !== 1'b0) begin
               errors++;
               $display("FAIL %s stall_done dut%0d: got %b expected 0", name, k, out_valid[k]);
            end
            tick();
            stall[k] = 1'b0;
            #1;
         end
         tick();
      end
      out_ready[k] = 1'b1;
      #1;
      checks++;
      if (out_valid[k] !== 1'b1 || out_rem[k] !== exp) begin
         errors++;
         $display("FAIL %s result dut%0d: got v=%b rem=%h expected v=1 rem=%h",
                  name, k, out_valid[k], out_rem[k], exp);
      end
      if (b2b) accept(k, prod2, poly2, exp2, 1'b1, name);
      else tick();
      out_ready[k] = 1'b0;
      if (!b2b) begin
         #1;
         checks++;
         if (out_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle dut%0d: got out_valid %b expected 0", name, k, out_valid[k]);
         end
      end
   endtask

   task automatic test_reset(int k);
      reset[k] = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || out_rem[k] !== 32'h0) begin
         errors++;
         $display("FAIL reset_state dut%0d: got rdy=%b v=%b busy=%b rem=%h expected 0 0 0 0",
                  k, in_ready[k], out_valid[k], busy[k], out_rem[k]);
      end
      reset[k] = 1'b0;
      #1;
      checks++;
      if (in_ready[k] !== 1'b1) begin
         errors++;
         $display("FAIL reset_release dut%0d: got in_ready %b expected 1", k, in_ready[k]);
      end
   endtask

   task automatic test_vectors(int k);
      accept(k, 64'h00000001_00000000, 32'h04C11DB7, 32'h04C11DB7, 1'b1, "modulus");
      wait_out(k, 0, "modulus");
      take(k, 0, 1'b0, 64'h0, 32'h0, 32'h0, "modulus");
      accept(k, 64'h00000000_DEADBEEF, 32'h04C11DB7, 32'hDEADBEEF, 1'b1, "low_degree");
      wait_out(k, 0, "low_degree");
      take(k, 0, 1'b0, 64'h0, 32'h0, 32'h0, "low_degree");
      accept(k, 64'h00000002_00000000, 32'h04C11DB7, 32'h09823B6E, 1'b1, "x33");
      wait_out(k, 0, "x33");
      take(k, 0, 1'b0, 64'h0, 32'h0, 32'h0, "x33");
      accept(k, 64'h12345678_9ABCDEF0, 32'h00000001, 32'h88888888, 1'b1, "x32_plus_1");
      wait_out(k, 0, "x32_plus_1");
      take(k, 0, 1'b0, 64'h0, 32'h0, 32'h0, "x32_plus_1");
   endtask

   task automatic test_stall(int k);
      logic [63:0] p;
      logic [31:0] g;
      p = {$urandom, $urandom};
      g = $urandom;
      accept(k, p, g, ref_mod(p, g), 1'b1, "stall_run");
      wait_out(k, (nsteps(k) > 1) ? 2 : 1, "stall_run");
      take(k, 0, 1'b0, 64'h0, 32'h0, 32'h0, "stall_run");
   endtask

   task automatic test_back_to_back(int k);
      logic [63:0] pa, pb;
      logic [31:0] ga, gb;
      pa = {$urandom, $urandom};
      pb = {$urandom, $urandom};
      ga = $urandom;
      gb = $urandom;
      accept(k, pa, ga, ref_mod(pa, ga), 1'b1, "b2b_first");
      wait_out(k, 0, "b2b_first");
      take(k, 3, 1'b1, pb, gb, ref_mod(pb, gb), "b2b_first");
      wait_out(k, 0, "b2b_second");
      take(k, 0, 1'b0, 64'h0, 32'h0, 32'h0, "b2b_second");
   endtask

   task automatic test_reset_abort(int k);
      int seen;
      accept(k, 64'hFFFF0000_1234ABCD, 32'h04C11DB7, 32'h0, 1'b0, "abort");
      if (nsteps(k) > 1) tick();
      reset[k] = 1'b1;
      stall[k] = 1'b1;
      tick();
      checks++;
      if (busy[k] !== 1'b0 || out_valid[k] !== 1'b0 || in_ready[k] !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset dut%0d: got busy=%b v=%b rdy=%b expected 0 0 0",
                  k, busy[k], out_valid[k], in_ready[k]);
      end
      stall[k] = 1'b0;
      reset[k] = 1'b0;
      #1;
      checks++;
      if (in_ready[k] !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready dut%0d: got %b expected 1", k, in_ready[k]);
      end
      seen = 0;
      for (int i = 0; i < nsteps(k) + 3; i++) begin
         tick();
         if (out_valid[k] === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_output dut%0d: got %0d valid cycles expected 0", k, seen);
      end
      accept(k, 64'h0, 32'h04C11DB7, 32'h0, 1'b1, "zero_prod");
      wait_out(k, 0, "zero_prod");
      take(k, 0, 1'b0, 64'h0, 32'h0, 32'h0, "zero_prod");
   endtask

   task automatic test_random(int k);
      logic [63:0] p;
      logic [31:0] g;
      for (int i = 0; i < 3; i++) begin
         p = {$urandom, $urandom};
         g = $urandom;
         accept(k, p, g, ref_mod(p, g), 1'b1, "random");
         wait_out(k, 0, "random");
         take(k, 0, 1'b0, 64'h0, 32'h0, 32'h0, "random");
      end
   endtask

   initial begin
      reset     = 3'b111;
      stall     = 3'b000;
      in_valid  = 3'b000;
      out_ready = 3'b000;
      in_prod   = '0;
      in_poly   = '0;
      tick();
      tick();
      reset = 3'b000;
      for (int k = 0; k < 3; k++) begin
         test_reset(k);
         test_vectors(k);
         test_stall(k);
         test_back_to_back(k);
         test_reset_abort(k);
         test_random(k);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
